ras_ctrl: RTL and testbench

- Front-end controller that sequences the return address stack (RAS) for the scalar core.
- Decodes fetched RV32 control-flow instructions and drives the RAS push/pop strobes and checkpoint strobes.
- Splits coroutine swaps into pop-then-push over two cycles, since the RAS gives push priority over pop.
- Tracks outstanding branch checkpoints and produces a registered return-target prediction for fetch.

---
 rtl/ras_ctrl.sv | 144 ++++++++++++++
 tb/tb_ras_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ras_ctrl.sv
// Return-address-stack sequencer: decodes RV32 control flow into RAS push/pop/checkpoint
// strobes, splits coroutine swaps into pop-then-push, and registers a return prediction.
module ras_ctrl #(
    parameter int CKPT_DEPTH = 8,
    parameter int CNT_W      = $clog2(CKPT_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [31:0]      instr_in,
    input  logic [31:0]      pc_in,
    output logic             ready_out,
    input  logic             must_flush,
    input  logic             branch_resolved,
    input  logic [31:0]      ras_pc,
    input  logic             ras_empty,
    output logic             ras_push,
    output logic             ras_pop,
    output logic [31:0]      ras_new_entry,
    output logic             ras_is_branch,
    output logic             ras_branch_resolved,
    output logic             ras_must_flush,
    output logic             pred_valid,
    output logic             pred_hit,
    output logic [31:0]      pred_target,
    output logic             o_dbg_state,
    output logic [CNT_W-1:0] o_dbg_cnt
);
    typedef enum logic {S_IDLE = 1'b0, S_SWAP_PUSH = 1'b1} state_t;

    localparam logic [CNT_W-1:0] L_FULL = CNT_W'(CKPT_DEPTH);
    localparam logic [CNT_W-1:0] L_ONE  = CNT_W'(1);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_swap_ret;
    logic             r_pred_valid;
    logic             r_pred_hit;
    logic [31:0]      r_pred_target;

    logic [6:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [2:0]  w_funct3;
    logic        w_is_jal;
    logic        w_is_jalr;
    logic        w_is_br;
    logic        w_link_rd;
    logic        w_link_rs1;
    logic        w_push_dec;
    logic        w_pop_dec;
    logic        w_swap;
    logic        w_ckpt;
    logic        w_ready;
    logic        w_acc;
    logic        w_br_res;
    logic [31:0] w_pc_plus4;

    assign w_opcode   = instr_in[6:0];
    assign w_rd       = instr_in[11:7];
    assign w_funct3   = instr_in[14:12];
    assign w_rs1      = instr_in[19:15];
    assign w_is_jal   = (w_opcode == 7'b1101111);
    assign w_is_jalr  = (w_opcode == 7'b1100111) && (w_funct3 == 3'b000);
    assign w_is_br    = (w_opcode == 7'b1100011);
    assign w_link_rd  = (w_rd == 5'd1) || (w_rd == 5'd5);
    assign w_link_rs1 = (w_rs1 == 5'd1) || (w_rs1 == 5'd5);
    assign w_push_dec = (w_is_jal || w_is_jalr) && w_link_rd;
    assign w_pop_dec  = w_is_jalr && w_link_rs1 && (!w_link_rd || (w_rd != w_rs1));
    assign w_swap     = w_is_jalr && w_link_rd && w_link_rs1 && (w_rd != w_rs1);
    assign w_ckpt     = w_is_br || w_is_jalr;
    assign w_pc_plus4 = pc_in + 32'd4;

    // A checkpointing instruction waits while every RAS checkpoint slot is in use.
    assign w_ready  = rst_n && (r_state == S_IDLE) && !(w_ckpt && (r_cnt == L_FULL));
    assign w_acc    = valid_in && w_ready && !must_flush;
    assign w_br_res = rst_n && branch_resolved && (r_cnt != '0) && !must_flush;

    assign ready_out           = w_ready;
    assign ras_branch_resolved = w_br_res;
    assign ras_must_flush      = rst_n && must_flush;

    always_comb begin
        w_next_state  = r_state;
        ras_push      = 1'b0;
        ras_pop       = 1'b0;
        ras_is_branch = 1'b0;
        ras_new_entry = w_pc_plus4;
        case (r_state)
            S_SWAP_PUSH: begin
                // Second half of a swap: push the saved link after the pop has landed.
                ras_push      = rst_n && !must_flush;
                ras_new_entry = r_swap_ret;
                w_next_state  = S_IDLE;
            end
            default: begin
                if (w_acc) begin
                    ras_push      = w_push_dec && !w_swap;
                    ras_pop       = w_pop_dec && !ras_empty;
                    ras_is_branch = w_ckpt;
                    if (w_swap) begin
                        w_next_state = S_SWAP_PUSH;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_swap_ret    <= '0;
            r_pred_valid  <= 1'b0;
            r_pred_hit    <= 1'b0;
            r_pred_target <= '0;
        end else begin
            r_state      <= w_next_state;
            r_pred_valid <= w_acc && w_pop_dec;
            r_pred_hit   <= w_acc && w_pop_dec && !ras_empty;
            // ras_pc is the pre-pop top of stack, i.e. the return target.
            if (w_acc && w_pop_dec) begin
                r_pred_target <= ras_pc;
            end
            if (w_acc && w_swap) begin
                r_swap_ret <= w_pc_plus4;
            end
            if (must_flush) begin
                r_cnt <= '0;
            end else if (ras_is_branch && !w_br_res) begin
                r_cnt <= r_cnt + L_ONE;
            end else if (!ras_is_branch && w_br_res) begin
                r_cnt <= r_cnt - L_ONE;
            end
        end
    end

    assign pred_valid  = r_pred_valid;
    assign pred_hit    = r_pred_hit;
    assign pred_target = r_pred_target;
    assign o_dbg_state = (r_state == S_SWAP_PUSH);
    assign o_dbg_cnt   = r_cnt;
endmodule

// File: tb/tb_ras_ctrl.sv
// Bench for ras_ctrl: directed call/return/swap/saturation/reset sequences then random
// traffic, checked against an instruction-level reference model through an expected queue.
module tb_ras_ctrl;
  localparam int DEPTH = 8;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic        ready;
    logic        push;
    logic        pop;
    logic [31:0] entry;
    logic        is_br;
    logic        br_res;
    logic        mflush;
    logic        pv;
    logic        ph;
    logic [31:0] pt;
    logic [CW-1:0] cnt;
    logic        st;
  } exp_t;
  localparam int W = $bits(exp_t);

  logic clk;
  logic rst_n;
  logic valid_in;
  logic [31:0] instr_in;
  logic [31:0] pc_in;
  logic ready_out;
  logic must_flush;
  logic branch_resolved;
  logic [31:0] ras_pc;
  logic ras_empty;
  logic ras_push;
  logic ras_pop;
  logic [31:0] ras_new_entry;
  logic ras_is_branch;
  logic ras_branch_resolved;
  logic ras_must_flush;
  logic pred_valid;
  logic pred_hit;
  logic [31:0] pred_target;
  logic dbg_state;
  logic [CW-1:0] dbg_cnt;

  ras_ctrl #(.CKPT_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .instr_in(instr_in), .pc_in(pc_in),
    .ready_out(ready_out), .must_flush(must_flush), .branch_resolved(branch_resolved),
    .ras_pc(ras_pc), .ras_empty(ras_empty), .ras_push(ras_push), .ras_pop(ras_pop),
    .ras_new_entry(ras_new_entry), .ras_is_branch(ras_is_branch),
    .ras_branch_resolved(ras_branch_resolved), .ras_must_flush(ras_must_flush),
    .pred_valid(pred_valid), .pred_hit(pred_hit), .pred_target(pred_target),
    .o_dbg_state(dbg_state), .o_dbg_cnt(dbg_cnt)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad = 0;

  // reference model state, in instruction-level terms
  int          m_cnt = 0;
  bit          m_swap_pending = 0;
  logic [31:0] m_swap_ret = 0;
  bit          m_pv = 0;
  bit          m_ph = 0;
  logic [31:0] m_pt = 0;

  function automatic logic [31:0] enc_jal(input logic [4:0] rd);
    logic [19:0] imm;
    imm = 20'($urandom);
    return {imm, rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [2:0] f3);
    logic [11:0] imm;
    imm = 12'($urandom);
    return {imm, rs1, f3, rd, 7'b1100111};
  endfunction

  function automatic logic [31:0] enc_beq(input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b000, 5'd8, 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rs1);
    return {7'd0, 5'd3, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic bit is_link(input int r);
    return (r == 1) || (r == 5);
  endfunction

  // Drives one cycle, records what the model says the DUT must show, advances the model.
  task automatic drive(input bit rst, input bit v, input logic [31:0] ins, input logic [31:0] pc,
                       input bit fl, input bit res, input logic [31:0] top, input bit emp);
    exp_t e;
    int   op, rd, rs1, f3;
    bit   call, ret, swap, ckpt, acc, br_res;
    rst_n = rst; valid_in = v; instr_in = ins; pc_in = pc;
    must_flush = fl; branch_resolved = res; ras_pc = top; ras_empty = emp;

    op = int'(ins[6:0]); rd = int'(ins[11:7]); rs1 = int'(ins[19:15]); f3 = int'(ins[14:12]);
    call = 0; ret = 0; swap = 0; ckpt = 0;
    if (op == 'h6f) call = is_link(rd);
    else if (op == 'h67 && f3 == 0) begin
      ckpt = 1;
      if (is_link(rd) && is_link(rs1) && rd == rs1) call = 1;
      else if (is_link(rd) && is_link(rs1)) swap = 1;
      else begin
        call = is_link(rd);
        ret = is_link(rs1);
      end
    end else if (op == 'h63) ckpt = 1;

    e = '0;
    e.pv = m_pv; e.ph = m_ph; e.pt = m_pt;
    e.cnt = CW'(m_cnt); e.st = m_swap_pending;
    e.entry = pc + 32'd4;
    if (!rst) begin
      m_swap_pending = 0; m_swap_ret = 0; m_cnt = 0;
      m_pv = 0; m_ph = 0; m_pt = 0;
    end else begin
      e.mflush = fl;
      br_res = res && (m_cnt > 0) && !fl;
      e.br_res = br_res;
      acc = 0;
      if (m_swap_pending) begin
        e.push = !fl;
        e.entry = m_swap_ret;
        m_swap_pending = 0;
      end else begin
        e.ready = !(ckpt && m_cnt == DEPTH);
        acc = v && e.ready && !fl;
        if (acc) begin
          e.is_br = ckpt;
          e.pop = (ret || swap) && !emp;
          e.push = call;
          if (swap) begin
            m_swap_pending = 1;
            m_swap_ret = pc + 32'd4;
          end
        end
      end
      m_pv = acc && (ret || swap);
      m_ph = m_pv && !emp;
      if (m_pv) m_pt = top;
      if (fl) m_cnt = 0;
      else m_cnt = m_cnt + int'(e.is_br) - int'(br_res);
    end
    exp_q.push_back(W'(e));
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, req, $time);
    end
  endtask

  // monitor: the DUT presents its strobes mid-cycle; pop one expectation per presented cycle
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_t'(exp_q.pop_front());
      chk("ready_out", 32'(ready_out), 32'(e.ready));
      chk("ras_push", 32'(ras_push), 32'(e.push));
      chk("ras_pop", 32'(ras_pop), 32'(e.pop));
      if (e.push) chk("ras_new_entry", ras_new_entry, e.entry);
      chk("ras_is_branch", 32'(ras_is_branch), 32'(e.is_br));
      chk("ras_branch_resolved", 32'(ras_branch_resolved), 32'(e.br_res));
      chk("ras_must_flush", 32'(ras_must_flush), 32'(e.mflush));
      chk("pred_valid", 32'(pred_valid), 32'(e.pv));
      chk("pred_hit", 32'(pred_hit), 32'(e.ph));
      chk("pred_target", pred_target, e.pt);
      chk("ckpt_cnt", 32'(dbg_cnt), 32'(e.cnt));
      chk("fsm_state", 32'(dbg_state), 32'(e.st));
    end
  end

  initial begin
    logic [31:0] nop;
    logic [31:0] ins;
    logic [4:0]  regs[4];
    nop = enc_add(5'd2, 5'd3);
    regs[0] = 5'd0; regs[1] = 5'd1; regs[2] = 5'd5; regs[3] = 5'd7;
    rst_n = 1'b0; valid_in = 1'b0; instr_in = nop; pc_in = 0;
    must_flush = 1'b0; branch_resolved = 1'b0; ras_pc = 0; ras_empty = 1'b1;
    @(posedge clk);
    #1;

    drive(0, 1, nop, 32'h0, 0, 1, 32'h0, 0);
    drive(0, 0, nop, 32'h0, 0, 0, 32'h0, 0);
    // call, returns with non-empty and empty RAS
    drive(1, 1, enc_jal(5'd1), 32'h100, 0, 0, 32'h0, 1);
    drive(1, 1, enc_jalr(5'd0, 5'd1, 3'b000), 32'h150, 0, 0, 32'h104, 0);
    drive(1, 1, enc_jalr(5'd0, 5'd1, 3'b000), 32'h160, 0, 0, 32'h555, 1);
    drive(1, 0, nop, 32'h0, 0, 0, 32'h0, 0);
    // push data wraps around
    drive(1, 1, enc_jal(5'd5), 32'hFFFF_FFFC, 0, 0, 32'h0, 0);
    // rd == rs1 link: push only
    drive(1, 1, enc_jalr(5'd1, 5'd1, 3'b000), 32'h300, 0, 0, 32'h44, 0);
    // swap, then swap flushed during its push cycle
    drive(1, 1, enc_jalr(5'd5, 5'd1, 3'b000), 32'h200, 0, 0, 32'h900, 0);
    drive(1, 1, enc_jal(5'd1), 32'h204, 0, 0, 32'h0, 0);
    drive(1, 1, nop, 32'h208, 0, 0, 32'h0, 0);
    drive(1, 1, enc_jalr(5'd1, 5'd5, 3'b000), 32'h400, 0, 0, 32'h910, 0);
    drive(1, 0, nop, 32'h0, 1, 0, 32'h0, 0);
    drive(1, 0, nop, 32'h0, 0, 0, 32'h0, 0);
    // saturate the checkpoint counter
    for (int i = 0; i < DEPTH; i++) drive(1, 1, enc_beq(5'd1, 5'd2), 32'h500 + 32'(4 * i), 0, 0, 32'h0, 0);
    drive(1, 1, enc_beq(5'd3, 5'd4), 32'h600, 0, 0, 32'h0, 0);
    drive(1, 1, nop, 32'h600, 0, 0, 32'h0, 0);
    drive(1, 1, enc_beq(5'd3, 5'd4), 32'h604, 0, 1, 32'h0, 0);
    drive(1, 1, enc_beq(5'd3, 5'd4), 32'h608, 0, 1, 32'h0, 0);
    drive(1, 1, enc_beq(5'd3, 5'd4), 32'h60c, 0, 0, 32'h0, 0);
    drive(1, 1, enc_beq(5'd3, 5'd4), 32'h610, 1, 0, 32'h0, 0);
    drive(1, 1, enc_jalr(5'd0, 5'd5, 3'b001), 32'h614, 0, 0, 32'h0, 0);
    // reset while a swap push is pending
    drive(1, 1, enc_jalr(5'd1, 5'd5, 3'b000), 32'h700, 0, 0, 32'hABC, 0);
    drive(0, 1, nop, 32'h704, 0, 1, 32'h0, 0);
    drive(1, 0, nop, 32'h0, 0, 0, 32'h0, 0);

    for (int n = 0; n < 1500; n++) begin
      logic [4:0] rd;
      logic [4:0] rs1;
      rd = regs[$urandom_range(0, 3)];
      rs1 = regs[$urandom_range(0, 3)];
      case ($urandom_range(0, 5))
        0: ins = enc_jal(rd);
        1, 2: ins = enc_jalr(rd, rs1, ($urandom_range(0, 7) == 0) ? 3'b010 : 3'b000);
        3, 4: ins = enc_beq(rs1, rd);
        default: ins = enc_add(rd, rs1);
      endcase
      drive($urandom_range(0, 99) != 0, $urandom_range(0, 9) < 8, ins, $urandom,
            $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0, $urandom,
            $urandom_range(0, 4) == 0);
    end

    @(negedge clk);
    #1;
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
